// File: rtl/instr_mem_responder_if.sv
// instr_mem_responder_if: fetch-side request/response and byte-wide memory read port.
interface instr_mem_responder_if #(parameter int ADDR_W = 16);
    logic              instr_req;
    logic [31:0]       instr_addr;
    logic [31:0]       instr;
    logic              instr_ready;
    logic              instr_fault;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              mem_rvalid;
    logic              busy;
    modport master (output instr_req, instr_addr, mem_rdata, mem_rvalid,
                    input instr, instr_ready, instr_fault, mem_rd, mem_addr, busy);
    modport slave (input instr_req, instr_addr, mem_rdata, mem_rvalid,
                   output instr, instr_ready, instr_fault, mem_rd, mem_addr, busy);
endinterface

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: assembles 32-bit instructions from four byte reads, with a one-word buffer and abort/restart.
module instr_mem_responder #(
    parameter int          ADDR_W    = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic clk,
    input logic reset,
    instr_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t            state;
    logic [ADDR_W-1:0] lat_addr, buf_addr, req_waddr;
    logic [31:0]       asm_word, buf_word;
    logic [1:0]        cnt;
    logic              abort, buf_valid, oor, bad, abort_now, restart, hold;
    assign req_waddr = {bus.instr_addr[ADDR_W-1:2], 2'b00};
    assign oor       = bus.instr_addr[31:ADDR_W] != '0;
    assign bad       = oor || bus.instr_addr[1:0] != 2'b00;
    assign abort_now = bus.instr_req && (oor || req_waddr != lat_addr) && (state == ISSUE || state == WAIT);
    assign restart   = abort || abort_now;
    // keeps instr_ready continuous when the same word is still being requested as DONE exits
    assign hold      = bus.instr_req && !bad && req_waddr == lat_addr;
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            bus.instr       <= '0;
            bus.instr_ready <= 1'b0;
            bus.instr_fault <= 1'b0;
            bus.mem_rd      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.busy        <= 1'b0;
            cnt             <= '0;
            abort           <= 1'b0;
            buf_valid       <= 1'b0;
        end else begin
            bus.mem_rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.instr_req && bad) begin
                        bus.instr       <= NOP_INSTR;
                        bus.instr_ready <= 1'b1;
                        bus.instr_fault <= 1'b1;
                    end else if (bus.instr_req && buf_valid && buf_addr == req_waddr) begin
                        bus.instr       <= buf_word;
                        bus.instr_ready <= 1'b1;
                        bus.instr_fault <= 1'b0;
                    end else if (bus.instr_req) begin
                        bus.instr_ready <= 1'b0;
                        lat_addr        <= req_waddr;
                        cnt             <= '0;
                        bus.mem_rd      <= 1'b1;
                        bus.mem_addr    <= req_waddr;
                        bus.busy        <= 1'b1;
                        state           <= ISSUE;
                    end else begin
                        bus.instr_ready <= 1'b0;
                    end
                end
                ISSUE: begin
                    bus.instr_ready <= 1'b0;
                    abort           <= restart;
                    state           <= WAIT;
                end
                WAIT: begin
                    if (!bus.mem_rvalid) begin
                        abort <= restart;
                    end else begin
                        asm_word[8*cnt +: 8] <= bus.mem_rdata;
                        if (restart) begin
                            abort        <= 1'b0;
                            lat_addr     <= req_waddr;
                            cnt          <= '0;
                            bus.mem_rd   <= 1'b1;
                            bus.mem_addr <= req_waddr;
                            state        <= ISSUE;
                        end else if (cnt == 2'd3) begin
                            bus.instr       <= {bus.mem_rdata, asm_word[23:0]};
                            bus.instr_ready <= 1'b1;
                            bus.instr_fault <= 1'b0;
                            state           <= DONE;
                        end else begin
                            cnt          <= cnt + 2'd1;
                            bus.mem_rd   <= 1'b1;
                            bus.mem_addr <= {lat_addr[ADDR_W-1:2], cnt + 2'd1};
                            state        <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    buf_addr        <= lat_addr;
                    buf_word        <= asm_word;
                    buf_valid       <= 1'b1;
                    bus.instr_ready <= hold;
                    bus.busy        <= 1'b0;
                    cnt             <= '0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: vector table, hand-written corner sequences and a randomized run against a word/buffer model.
module tb_instr_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_mem_responder_if #(.ADDR_W(16)) bus();
    instr_mem_responder #(.ADDR_W(16), .NOP_INSTR(32'h0000_0013)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        logic        fault;
        int          reads;
        int          cycles;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    int          lat = 1;
    bit          rand_lat = 0;
    int          pend = 0;
    logic [15:0] pa;
    logic [15:0] rd_log[$];
    logic [7:0]  mem[0:65535];
    vec_t        v[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [15:0] a);
        return {mem[a + 16'd3], mem[a + 16'd2], mem[a + 16'd1], mem[a]};
    endfunction

    // byte memory: answers each sampled mem_rd after lat cycles, flags overlapping reads
    initial begin
        logic        rd_s;
        logic [15:0] a_s;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(posedge clk);
            rd_s = bus.mem_rd;
            a_s  = bus.mem_addr;
            #1;
            bus.mem_rvalid = 1'b0;
            if (rd_s) begin
                tests++;
                if (pend != 0) begin
                    fails++;
                    $display("FAIL mem_rd_overlap: read at 0x%04h issued with %0d cycles still pending, required 0", a_s, pend);
                end
                rd_log.push_back(a_s);
                pa   = a_s;
                pend = rand_lat ? int'($urandom_range(1, 3)) : lat;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = mem[pa];
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input bit keep, output logic [31:0] w, output logic f,
                         output int n, output int nr, output bit ok);
        rd_log.delete();
        bus.instr_addr = a;
        bus.instr_req  = 1'b1;
        n  = 0;
        ok = 0;
        while (n < 200 && !ok) begin
            @(posedge clk); #1;
            n++;
            ok = bus.instr_ready;
        end
        w  = bus.instr;
        f  = bus.instr_fault;
        nr = rd_log.size();
        if (!keep) begin
            bus.instr_req = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] w, a, ew, mba;
        logic        f, ef, mbv;
        int          n, nr, er;
        bit          ok;
        logic [15:0] exp_ab[6];
        bus.instr_req  = 1'b0;
        bus.instr_addr = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5a;
        mem[0] = 8'h93; mem[1] = 8'h00; mem[2] = 8'h10; mem[3] = 8'h00;
        v[0] = '{32'h0000_0000, 32'h0010_0093, 1'b0, 0, 1};
        v[1] = '{32'h0000_0004, 32'h5d5c_5f5e, 1'b0, 4, 9};
        v[2] = '{32'h0000_0000, 32'h0010_0093, 1'b0, 4, 9};
        v[3] = '{32'h0001_0000, 32'h0000_0013, 1'b1, 0, 1};
        v[4] = '{32'h0000_0002, 32'h0000_0013, 1'b1, 0, 1};
        v[5] = '{32'h0000_0000, 32'h0010_0093, 1'b0, 0, 1};
        v[6] = '{32'h0000_fffc, 32'ha5a4_a7a6, 1'b0, 4, 9};
        v[7] = '{32'hffff_fffc, 32'h0000_0013, 1'b1, 0, 1};
        v[8] = '{32'h0000_fffc, 32'ha5a4_a7a6, 1'b0, 0, 1};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_ready", 32'(bus.instr_ready), 32'h0);
        chk("rst_fault", 32'(bus.instr_fault), 32'h0);
        chk("rst_mem_rd", 32'(bus.mem_rd), 32'h0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);

        // first miss, then the request is held: ready must stay high with no more reads
        fetch(32'h0, 1, w, f, n, nr, ok);
        chk("miss0_ok", 32'(ok), 32'h1);
        chk("miss0_word", w, 32'h0010_0093);
        chk("miss0_fault", 32'(f), 32'h0);
        chk("miss0_cycles", 32'(n), 32'd9);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("hold_ready", 32'(bus.instr_ready), 32'h1);
            chk("hold_word", bus.instr, 32'h0010_0093);
        end
        chk("hold_reads", 32'(rd_log.size()), 32'd4);
        for (int k = 0; k < rd_log.size() && k < 4; k++) chk("miss0_rd_addr", 32'(rd_log[k]), 32'(k));
        bus.instr_req = 1'b0;
        @(posedge clk); #1;
        chk("drop_ready", 32'(bus.instr_ready), 32'h0);

        for (int i = 0; i < 9; i++) begin
            fetch(v[i].addr, 0, w, f, n, nr, ok);
            chk("vec_ok", 32'(ok), 32'h1);
            chk("vec_word", w, v[i].word);
            chk("vec_fault", 32'(f), 32'(v[i].fault));
            chk("vec_reads", 32'(nr), 32'(v[i].reads));
            chk("vec_cycles", 32'(n), 32'(v[i].cycles));
        end

        // abort: change address once the byte-1 read is on the bus
        exp_ab = '{16'h8, 16'h9, 16'h10, 16'h11, 16'h12, 16'h13};
        rd_log.delete();
        bus.instr_addr = 32'h8;
        bus.instr_req  = 1'b1;
        n = 0;
        while (n < 50 && !(bus.mem_rd && bus.mem_addr == 16'h9)) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_byte1_seen", 32'(n < 50), 32'h1);
        bus.instr_addr = 32'h10;
        n  = 0;
        ok = 0;
        while (n < 100 && !ok) begin
            @(posedge clk); #1;
            n++;
            ok = bus.instr_ready;
        end
        chk("abort_ok", 32'(ok), 32'h1);
        chk("abort_word", bus.instr, 32'h4948_4b4a);
        chk("abort_reads", 32'(rd_log.size()), 32'd6);
        for (int k = 0; k < rd_log.size() && k < 6; k++) chk("abort_rd_addr", 32'(rd_log[k]), 32'(exp_ab[k]));
        bus.instr_req = 1'b0;
        @(posedge clk); #1;

        lat = 4;
        fetch(32'h30, 0, w, f, n, nr, ok);
        chk("slow_word", w, 32'h6968_6b6a);
        chk("slow_cycles", 32'(n), 32'd21);
        chk("slow_reads", 32'(nr), 32'd4);
        lat = 1;

        // reset during WAIT with a late byte still in flight
        fetch(32'h20, 0, w, f, n, nr, ok);
        chk("pre_rst_word", w, 32'h7978_7b7a);
        lat = 6;
        bus.instr_addr = 32'h24;
        bus.instr_req  = 1'b1;
        n = 0;
        while (n < 20 && !bus.mem_rd) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        bus.instr_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_instr", bus.instr, 32'h0);
        chk("mid_rst_ready", 32'(bus.instr_ready), 32'h0);
        chk("mid_rst_fault", 32'(bus.instr_fault), 32'h0);
        chk("mid_rst_mem_rd", 32'(bus.mem_rd), 32'h0);
        chk("mid_rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("mid_rst_busy", 32'(bus.busy), 32'h0);
        n = 0;
        while (n < 20 && pend != 0) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        chk("stale_busy", 32'(bus.busy), 32'h0);
        chk("stale_ready", 32'(bus.instr_ready), 32'h0);
        lat = 1;
        fetch(32'h20, 0, w, f, n, nr, ok);
        chk("post_rst_reads", 32'(nr), 32'd4);
        chk("post_rst_word", w, 32'h7978_7b7a);

        // randomized requests against a word/buffer model
        rand_lat = 1;
        mbv = 1'b1;
        mba = 32'h20;
        a   = 32'h20;
        for (int t = 0; t < 40; t++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = {16'(1 + $urandom_range(0, 1000)), 16'(4 * $urandom_range(0, 15))};
            else if (r == 1) a = {26'h0, 4'($urandom_range(0, 15)), 2'(1 + $urandom_range(0, 2))};
            else if (r > 3)  a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            if (a[31:16] != 16'h0 || a[1:0] != 2'b00) begin
                ew = 32'h0000_0013; ef = 1'b1; er = 0;
            end else if (mbv && mba == a) begin
                ew = word_at(a[15:0]); ef = 1'b0; er = 0;
            end else begin
                ew = word_at(a[15:0]); ef = 1'b0; er = 4;
                mbv = 1'b1; mba = a;
            end
            fetch(a, 0, w, f, n, nr, ok);
            chk("rnd_ok", 32'(ok), 32'h1);
            chk("rnd_word", w, ew);
            chk("rnd_fault", 32'(f), 32'(ef));
            chk("rnd_reads", 32'(nr), 32'(er));
            if (er == 0) chk("rnd_cycles", 32'(n), 32'd1);
            else for (int k = 0; k < rd_log.size() && k < 4; k++) chk("rnd_rd_addr", 32'(rd_log[k]), 32'(a[15:0]) + 32'(k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
